// File: rtl/hw_rr_arbiter.sv
// Round-robin arbiter for 2**n requesters with a registered one-hot grant and a max hold time.
// Each release rotates the search start to just past the releasing owner, so no requester starves.
module hw_rr_arbiter #(
    parameter int n        = 2,
    parameter int MAX_HOLD = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2**n-1:0] req,
    output logic [2**n-1:0] gnt,
    output logic [n-1:0]    gnt_id,
    output logic            gnt_valid
);

    localparam int N  = 2 ** n;
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [n-1:0]  ID_ONE    = n'(1);

    // state_q is the FSM state; checkers can bind to it directly.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [n-1:0]  owner_q, owner_d;
    logic [n-1:0]  ptr_q,   ptr_d;
    logic [HW-1:0] hold_q,  hold_d;

    logic [n-1:0]  search_start;
    logic [n-1:0]  winner;
    logic          winner_found;
    logic          release_now;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    // While granted, the search for the next owner starts just past the current owner.
    always_comb begin
        search_start = ptr_q;
        if (state_q == GRANT) begin
            search_start = owner_q + ID_ONE;
        end
    end

    // Rotating search; n-bit index arithmetic wraps modulo N on its own.
    always_comb begin
        logic [n-1:0] idx;
        winner       = '0;
        winner_found = 1'b0;
        idx          = '0;
        for (int i = 0; i < N; i++) begin
            idx = search_start + i[n-1:0];
            if (!winner_found && req[idx]) begin
                winner       = idx;
                winner_found = 1'b1;
            end
        end
    end

    always_comb begin
        release_now = 1'b0;
        if (state_q == GRANT) begin
            release_now = !req[owner_q] || (hold_q == HOLD_LAST);
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (winner_found) begin
                    state_d = GRANT;
                    owner_d = winner;
                    hold_d  = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    ptr_d  = owner_q + ID_ONE;
                    hold_d = '0;
                    // A still-requesting sole owner at expiry wraps back to itself here.
                    if (winner_found) begin
                        owner_d = winner;
                    end else begin
                        state_d = IDLE;
                        owner_d = '0;
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                owner_d = '0;
                hold_d  = '0;
            end
        endcase
    end

    // Outputs are decoded from registers only, so they carry no combinational path from req.
    always_comb begin
        gnt       = '0;
        gnt_id    = '0;
        gnt_valid = 1'b0;
        if (state_q == GRANT) begin
            gnt[owner_q] = 1'b1;
            gnt_id       = owner_q;
            gnt_valid    = 1'b1;
        end
    end

endmodule

// File: tb/tb_hw_rr_arbiter.sv
// Bench for hw_rr_arbiter: directed scenarios plus random traffic, all outputs compared each
// cycle against an integer-based round-robin reference model.
module tb_hw_rr_arbiter;

    localparam int n        = 2;
    localparam int N        = 2 ** n;
    localparam int MAX_HOLD = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [n-1:0] gnt_id;
    logic         gnt_valid;

    int errors;
    int checks;

    // Reference model: owner is -1 when idle; held counts cycles the owner has had the grant.
    int m_owner;
    int m_ptr;
    int m_held;

    hw_rr_arbiter #(.n(n), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    // Clock and reset defaults.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int start);
        for (int k = 0; k < N; k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [N-1:0] r, input logic rs);
        if (rs) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
        end else if (m_owner < 0) begin
            m_owner = pick(r, m_ptr);
            m_held  = (m_owner >= 0) ? 1 : 0;
        end else if (!r[m_owner] || m_held >= MAX_HOLD) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = pick(r, m_ptr);
            m_held  = (m_owner >= 0) ? 1 : 0;
        end else begin
            m_held++;
        end
    endtask

    // One clock: apply inputs, let the edge happen, then compare at the falling edge.
    task automatic cycle(input logic [N-1:0] r, input logic rs);
        logic [N-1:0] e_gnt;
        logic [n-1:0] e_id;
        req = r;
        rst = rs;
        @(posedge clk);
        model_step(r, rs);
        @(negedge clk);
        e_gnt = '0;
        e_id  = '0;
        if (m_owner >= 0) begin
            e_gnt[m_owner] = 1'b1;
            e_id = m_owner[n-1:0];
        end
        check("gnt", 32'(gnt), 32'(e_gnt));
        check("gnt_id", 32'(gnt_id), 32'(e_id));
        check("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
        check("onehot0", 32'($onehot0(gnt)), 32'd1);
    endtask

    initial begin
        logic [N-1:0] r;
        errors  = 0;
        checks  = 0;
        m_owner = -1;
        m_ptr   = 0;
        m_held  = 0;
        req     = '0;
        rst     = 1'b1;
        @(negedge clk);

        // 1: reset with all requesting, then release.
        for (int i = 0; i < 3; i++) begin
            cycle(4'b1111, 1'b1);
            check("t1_rst_gnt", 32'(gnt), 32'h0);
        end
        cycle(4'b1111, 1'b0);
        check("t1_first_gnt", 32'(gnt), 32'b0001);

        // 2: all requesting keeps rotating in blocks of MAX_HOLD; continue from the first grant.
        for (int i = 1; i < 20; i++) begin
            cycle(4'b1111, 1'b0);
            check("t2_seq", 32'(gnt), 32'(1 << ((i / MAX_HOLD) % N)));
        end

        // 3: owner 0 drops after 2 granted cycles, grant passes to 1 without a gap.
        cycle(4'b0000, 1'b1);
        cycle(4'b0011, 1'b0);
        cycle(4'b0011, 1'b0);
        cycle(4'b0010, 1'b0);
        check("t3_handoff", 32'(gnt), 32'b0010);
        check("t3_id", 32'(gnt_id), 32'd1);

        // 4: lone requester is re-granted across expiry, then idles.
        cycle(4'b0000, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cycle(4'b0100, 1'b0);
            check("t4_hold", 32'(gnt), 32'b0100);
        end
        cycle(4'b0000, 1'b0);
        check("t4_idle", 32'(gnt_valid), 32'd0);

        // 5: owner 3 expires with 0 waiting, pointer wraps.
        cycle(4'b0000, 1'b1);
        cycle(4'b1000, 1'b0);
        for (int i = 1; i < MAX_HOLD; i++) cycle(4'b1001, 1'b0);
        check("t5_before", 32'(gnt), 32'b1000);
        cycle(4'b1001, 1'b0);
        check("t5_wrap", 32'(gnt), 32'b0001);

        // 6: reset mid-grant returns the pointer to 0.
        cycle(4'b0000, 1'b1);
        cycle(4'b0100, 1'b0);
        cycle(4'b1111, 1'b0);
        check("t6_pre", 32'(gnt), 32'b0100);
        cycle(4'b1111, 1'b1);
        check("t6_rst", 32'(gnt), 32'h0);
        cycle(4'b1111, 1'b0);
        check("t6_ptr0", 32'(gnt), 32'b0001);

        // Random traffic with occasional resets and sparse request patterns.
        for (int i = 0; i < 400; i++) begin
            r = N'($urandom_range(0, 2 ** N - 1));
            if ($urandom_range(0, 3) == 0) r = r & N'($urandom_range(0, 2 ** N - 1));
            cycle(r, $urandom_range(0, 49) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
